// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer,
// full-scan snapshot classification and press/release debounce.
module keypad_scanner #(
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DMAX = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE);
  localparam bit DB1 = (DEBOUNCE == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DB,
    S_PRESSED,
    S_REL_DB
  } state_t;

  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_ptr;
  logic [3:0]    r_col_n;
  logic [15:0]   r_snap;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic          r_valid;
  logic [3:0]    r_code;
  logic          r_held;

  logic          w_tick;
  logic          w_scan_end;
  logic [15:0]   w_snap;
  logic [4:0]    w_ones;
  logic [3:0]    w_code;
  logic          w_none;
  logic          w_single;
  logic [CW-1:0] w_cnt_inc;

  assign w_tick     = (r_div == DMAX);
  assign w_scan_end = w_tick && (r_ptr == 2'd3);

  // Snapshot as it will look once the current column is captured.
  always_comb begin
    w_snap = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_snap[{2'(r), r_ptr}] = ~r_row_s2[r];
    end
  end

  always_comb begin
    w_ones = 5'd0;
    w_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_snap[i]) begin
        w_ones = w_ones + 5'd1;
        w_code = 4'(i);
      end
    end
  end

  assign w_none    = (w_ones == 5'd0);
  assign w_single  = (w_ones == 5'd1);
  assign w_cnt_inc = (r_cnt == DB) ? DB : r_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= 4'b1111;
      r_row_s2 <= 4'b1111;
      r_div    <= '0;
      r_ptr    <= 2'd0;
      r_col_n  <= 4'b1110;
      r_snap   <= 16'd0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      if (w_tick) begin
        r_div   <= '0;
        r_ptr   <= r_ptr + 2'd1;
        r_col_n <= ~(4'b0001 << (r_ptr + 2'd1));
        r_snap  <= w_snap;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'd0;
      r_valid <= 1'b0;
      r_code  <= 4'd0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_scan_end) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_code;
              if (DB1) begin
                r_code  <= w_code;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_PRESSED;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_PRESS_DB;
              end
            end
          end
          S_PRESS_DB: begin
            if (w_single && (w_code == r_cand)) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DB) begin
                r_code  <= w_code;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_PRESSED;
              end
            end else if (w_single) begin
              r_cand <= w_code;
              r_cnt  <= CW'(1);
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            if (w_none) begin
              if (DB1) begin
                r_held  <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_REL_DB;
              end
            end
          end
          S_REL_DB: begin
            if (w_none) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == DB) begin
                r_held  <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_PRESSED;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign col_n     = r_col_n;
  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix model of pressed keys,
// SCAN_DIV=4 (16-clk scans) and DEBOUNCE=2.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] keys;
  int          cyc;
  int          pulses;
  int          n_checks;
  int          n_errors;
  int          p0;
  int          base;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[4*r +: 4] & ~col_n);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (key_valid) pulses <= pulses + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at_cyc(input int t);
    int n = 0;
    while (cyc != t && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != t) chk("at_cyc_timeout", cyc, t);
  endtask

  task automatic next_scan;
    base = (cyc / 16 + 1) * 16;
    at_cyc(base);
  endtask

  task automatic scans(input int n);
    repeat (16 * n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] e;
    n_checks = 0;
    n_errors = 0;
    pulses   = 0;
    keys     = 16'd0;
    rst_n    = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_col", col_n, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'd0);
    chk("rst_held", key_held, 1'b0);
    rst_n = 1'b1;

    // idle column rotation
    for (int k = 0; k < 16; k++) begin
      at_cyc(k);
      e = ~(4'b0001 << ((k / 4) % 4));
      chk("col_seq", col_n, e);
    end
    p0 = pulses;
    scans(3);
    chk("idle_pulses", pulses - p0, 0);
    chk("idle_code", key_code, 4'd0);
    chk("idle_held", key_held, 1'b0);

    // key 9 stable from reset release
    keys[9] = 1'b1;
    do_reset;
    p0 = pulses;
    at_cyc(31);
    chk("k9_pre", key_valid, 1'b0);
    at_cyc(32);
    chk("k9_valid", key_valid, 1'b1);
    chk("k9_code", key_code, 4'd9);
    chk("k9_held", key_held, 1'b1);
    at_cyc(33);
    chk("k9_post", key_valid, 1'b0);
    scans(8);
    chk("k9_pulses", pulses - p0, 1);
    chk("k9_still_held", key_held, 1'b1);

    // release, then bounce key 9 for two scans
    keys[9] = 1'b0;
    scans(4);
    chk("rel_held", key_held, 1'b0);
    next_scan;
    p0 = pulses;
    for (int j = 0; j < 32; j++) begin
      keys[9] = (((j + 1) / 3) % 2 == 0);
      @(negedge clk);
    end
    keys[9] = 1'b1;
    chk("bounce_pulses", pulses - p0, 0);
    at_cyc(base + 63);
    chk("bounce_pre", key_valid, 1'b0);
    at_cyc(base + 64);
    chk("bounce_valid", key_valid, 1'b1);
    chk("bounce_code", key_code, 4'd9);
    scans(3);
    chk("bounce_once", pulses - p0, 1);

    // 9 held, add 6, drop 9
    p0 = pulses;
    keys[6] = 1'b1;
    scans(3);
    keys[9] = 1'b0;
    scans(3);
    chk("multi_pulses", pulses - p0, 0);
    chk("multi_held", key_held, 1'b1);
    chk("multi_code", key_code, 4'd9);
    keys[6] = 1'b0;
    scans(4);
    chk("multi_rel", key_held, 1'b0);
    keys[6] = 1'b1;
    scans(4);
    chk("k6_pulses", pulses - p0, 1);
    chk("k6_code", key_code, 4'd6);

    // short release does not end the hold
    keys[6] = 1'b0;
    scans(4);
    keys[9] = 1'b1;
    scans(4);
    chk("k9b_code", key_code, 4'd9);
    p0 = pulses;
    next_scan;
    keys[9] = 1'b0;
    scans(1);
    keys[9] = 1'b1;
    scans(3);
    chk("short_held", key_held, 1'b1);
    chk("short_pulses", pulses - p0, 0);
    next_scan;
    keys[9] = 1'b0;
    at_cyc(base + 31);
    chk("long_held_pre", key_held, 1'b1);
    at_cyc(base + 32);
    chk("long_held_post", key_held, 1'b0);
    keys[15] = 1'b1;
    scans(4);
    chk("k15_code", key_code, 4'd15);
    chk("k15_pulses", pulses - p0, 1);
    keys[15] = 1'b0;
    scans(4);

    // reset while key 9 is held
    keys[9] = 1'b1;
    scans(4);
    chk("pre_rst_code", key_code, 4'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", col_n, 4'b1110);
    chk("mid_rst_valid", key_valid, 1'b0);
    chk("mid_rst_code", key_code, 4'd0);
    chk("mid_rst_held", key_held, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    at_cyc(16);
    chk("rr_code_wait", key_code, 4'd0);
    at_cyc(31);
    chk("rr_pre", key_valid, 1'b0);
    at_cyc(32);
    chk("rr_valid", key_valid, 1'b1);
    chk("rr_code", key_code, 4'd9);
    chk("rr_held", key_held, 1'b1);
    at_cyc(33);
    chk("rr_post", key_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed seven-segment display driver.
- The display drives digit selects and outputs segments. This block drives 4 column selects of a 4x4 matrix keypad and reads 4 row lines back.
- It debounces the scan result and emits one pulse plus a hex key code per press. The code feeds the same digit register a board button increments today.

Parameters:
- SCAN_DIV, 1024: clk cycles each column is held low (column dwell).
- DEBOUNCE, 4: consecutive identical full scans required to accept a press or a release (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- row_n  input  4  keypad rows; pulled up, low = key in the driven column pressed; asynchronous to clk.
- col_n  output  4  column drive; exactly one bit low at any time.
- key_valid  output  1  one-clk pulse on each accepted press.
- key_code  output  4  code of the last accepted key = row*4 + col; held between presses.
- key_held  output  1  high while the accepted key is considered pressed.

Behaviour:
- Reset (async assert, sync-release use): col_n=4'b1110, column pointer=0, dwell counter=0, key_valid=0, key_code=0, key_held=0, FSM=IDLE, debounce count=0, scan snapshot cleared, synchronizer flops=4'b1111.
- row_n passes through a 2-flop synchronizer before any use.
- Dwell counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1 (column tick), synchronized rows for the current column are captured into bits [4r+c] of a 16-bit snapshot (1 = pressed).
  - The column pointer then advances mod 4; col_n = ~(1<<ptr).
- Sampling at dwell end gives settle time; the synchronizer adds 2 cycles, so SCAN_DIV>=3 is required.
- Scan end is the tick of column 3. On it the snapshot is classified as:
  - NONE: 0 bits set.
  - SINGLE(code): exactly 1 bit set.
  - MULTI: >=2 bits set. Ghosting/rollover is not supported and is treated as NONE for press detection and as "not released" for release detection.
- FSM, evaluated only at scan ends:
  - IDLE: SINGLE(k) -> candidate=k, cnt=1, go PRESS_DB. If DEBOUNCE==1, go directly to accept.
  - PRESS_DB:
    - SINGLE(candidate) -> cnt+1; when cnt reaches DEBOUNCE, accept.
    - SINGLE(other) -> candidate=other, cnt=1.
    - NONE/MULTI -> IDLE.
  - Accept: key_code<=candidate, key_valid=1 for exactly the next clk, key_held=1, go PRESSED.
  - PRESSED:
    - NONE -> cnt=1, go REL_DB (if DEBOUNCE==1, go straight to IDLE).
    - Anything else -> stay. A different key while held is not reported.
  - REL_DB:
    - NONE -> cnt+1; at DEBOUNCE go IDLE, key_held=0.
    - Non-NONE -> back to PRESSED, cnt cleared.
- Latency: with a key stable before scan start, key_valid is asserted 1 clk after the scan end of the DEBOUNCE-th consecutive SINGLE scan. Worst case is (DEBOUNCE+1)*4*SCAN_DIV+3 clks after the press.
- key_code changes only on accept; unaffected by release.
- Counters wrap only at their defined limits. Debounce count saturates at DEBOUNCE.
- Reset mid-operation: all state returns to reset values immediately; a key still held after reset must be re-debounced and re-reported.

Test Plan (SCAN_DIV=4, DEBOUNCE=2):
- After reset, no keys: col_n cycles 1110,1101,1011,0111, changing every 4 clks; key_valid never high; key_code=0, key_held=0.
- Model presses key r=2,c=1 (row_n[2] low whenever col_n[1]==0), held 10 scans -> exactly one key_valid pulse, key_code=9, key_held=1. Pulse falls on the clk after the 2nd full scan end that sees the key.
- Key 9 bouncing, toggling every 3 clks for 2 scans, then stable -> no pulse during bounce; one pulse with code 9 after 2 stable scans; never two pulses.
- Key 9 held, then key 6 also pressed (MULTI), then 9 released leaving 6 -> no new pulse, key_held stays 1 until all keys released for 2 scans; then press 6 -> pulse, key_code=6.
- Release key 9 for 1 scan then re-press -> key_held stays 1, no new pulse. Release for 2 scans -> key_held=0; next press of key 15 (r3,c3) -> pulse, key_code=15.
- Assert rst_n=0 for 1 clk mid-PRESSED with key 9 still held -> outputs return to reset values immediately; after release of reset a fresh pulse with key_code=9 appears after 2 scans.
